// File: rtl/l2_cache_control.sv
// l2_cache_control: L2 controller FSM answering the arbiter handshake; tag check, dirty-victim
// writeback, line allocate from pmem, LRU/dirty strobes and saturating hit/miss counters.
module l2_cache_control #(
  parameter int WAY_W = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_mem_read,
  input  logic             i_mem_write,
  output logic             o_mem_resp,
  input  logic             i_hit,
  input  logic [WAY_W-1:0] i_hit_way,
  input  logic [WAY_W-1:0] i_lru_way,
  input  logic             i_victim_dirty,
  output logic             o_pmem_read,
  output logic             o_pmem_write,
  input  logic             i_pmem_resp,
  output logic [WAY_W-1:0] o_way_sel,
  output logic             o_data_src,
  output logic             o_addr_sel,
  output logic             o_load_data,
  output logic             o_load_tag,
  output logic             o_set_dirty,
  output logic             o_clear_dirty,
  output logic             o_load_lru,
  output logic [CNT_W-1:0] o_hit_count,
  output logic [CNT_W-1:0] o_miss_count
);
  typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, ALLOCATE} state_t;
  state_t r_state, w_next;
  logic r_refill;
  logic [CNT_W-1:0] r_hit_count, r_miss_count;
  logic w_req, w_count;
  assign w_req = i_mem_read | i_mem_write;
  // the post-refill re-check is a guaranteed hit and must not skew the statistics
  assign w_count = (r_state == CHECK) && w_req && !r_refill;
  assign o_hit_count = r_hit_count;
  assign o_miss_count = r_miss_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_refill <= 1'b0;
      r_hit_count <= '0;
      r_miss_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ALLOCATE && i_pmem_resp) r_refill <= 1'b1;
      else if (r_state == CHECK) r_refill <= 1'b0;
      if (w_count && i_hit && !(&r_hit_count)) r_hit_count <= r_hit_count + 1'b1;
      if (w_count && !i_hit && !(&r_miss_count)) r_miss_count <= r_miss_count + 1'b1;
    end
  end
  always_comb begin
    w_next = r_state;
    o_mem_resp = 1'b0;
    o_pmem_read = 1'b0;
    o_pmem_write = 1'b0;
    o_way_sel = '0;
    o_data_src = 1'b0;
    o_addr_sel = 1'b0;
    o_load_data = 1'b0;
    o_load_tag = 1'b0;
    o_set_dirty = 1'b0;
    o_clear_dirty = 1'b0;
    o_load_lru = 1'b0;
    case (r_state)
      IDLE: w_next = w_req ? CHECK : IDLE;
      CHECK: begin
        if (!w_req) w_next = IDLE;
        else if (i_hit) begin
          w_next = IDLE;
          o_mem_resp = 1'b1;
          o_load_lru = 1'b1;
          o_way_sel = i_hit_way;
          o_load_data = i_mem_write;
          o_set_dirty = i_mem_write;
        end else w_next = i_victim_dirty ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        o_pmem_write = 1'b1;
        o_addr_sel = 1'b1;
        o_way_sel = i_lru_way;
        w_next = i_pmem_resp ? ALLOCATE : WRITEBACK;
      end
      ALLOCATE: begin
        o_pmem_read = 1'b1;
        o_way_sel = i_lru_way;
        o_load_data = i_pmem_resp;
        o_data_src = i_pmem_resp;
        o_load_tag = i_pmem_resp;
        o_clear_dirty = i_pmem_resp;
        w_next = i_pmem_resp ? CHECK : ALLOCATE;
      end
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_l2_cache_control.sv
// tb_l2_cache_control: randomized transactions against a transaction-level latency/counter model;
// a negedge monitor pops expected responses from a scoreboard queue.
module tb_l2_cache_control;
  localparam int WAY_W = 1;
  localparam int CNT_W = 2;
  localparam int MAXC = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_read = 1'b0, mem_write = 1'b0, hit = 1'b0, victim_dirty = 1'b0, pmem_resp = 1'b0;
  logic [WAY_W-1:0] hit_way = '0, lru_way = '0;
  logic mem_resp, pmem_read, pmem_write, data_src, addr_sel, load_data, load_tag;
  logic set_dirty, clear_dirty, load_lru;
  logic [WAY_W-1:0] way_sel;
  logic [CNT_W-1:0] hit_count, miss_count;
  typedef struct {
    int lat;
    int way;
    bit wr;
    int lw;
    int hc;
    int mc;
    int start;
  } exp_t;
  exp_t q[$];
  exp_t want;
  int total = 0, bad = 0, cyc = 0, mhc = 0, mmc = 0, pend_hc = 0, pend_mc = 0;
  bit busy = 1'b0, cnt_pend = 1'b0;

  l2_cache_control #(.WAY_W(WAY_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_mem_read(mem_read), .i_mem_write(mem_write), .o_mem_resp(mem_resp),
    .i_hit(hit), .i_hit_way(hit_way), .i_lru_way(lru_way), .i_victim_dirty(victim_dirty),
    .o_pmem_read(pmem_read), .o_pmem_write(pmem_write), .i_pmem_resp(pmem_resp), .o_way_sel(way_sel),
    .o_data_src(data_src), .o_addr_sel(addr_sel), .o_load_data(load_data), .o_load_tag(load_tag),
    .o_set_dirty(set_dirty), .o_clear_dirty(clear_dirty), .o_load_lru(load_lru),
    .o_hit_count(hit_count), .o_miss_count(miss_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic int all_outs();
    return int'({mem_resp, pmem_read, pmem_write, way_sel, data_src, addr_sel, load_data, load_tag,
                 set_dirty, clear_dirty, load_lru});
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("pmem_exclusive", int'(pmem_read & pmem_write), 0);
      if (cnt_pend) begin
        chk("hit_count", int'(hit_count), pend_hc);
        chk("miss_count", int'(miss_count), pend_mc);
        cnt_pend = 1'b0;
      end
      if (!busy) chk("idle_quiet", all_outs(), 0);
      if (pmem_write) chk("wb_addr_sel", int'(addr_sel), 1);
      if (pmem_read) chk("alloc_addr_sel", int'(addr_sel), 0);
      if ((pmem_read | pmem_write) && q.size() > 0) chk("pmem_way", int'(way_sel), q[0].lw);
      if (load_tag) begin
        if (q.size() == 0) chk("fill_unexpected", 1, 0);
        else begin
          chk("fill_way", int'(way_sel), q[0].lw);
          chk("fill_strobes", int'({load_data, data_src, clear_dirty, pmem_read, pmem_resp}), 31);
          chk("fill_quiet", int'({set_dirty, load_lru, mem_resp}), 0);
        end
      end
      if (mem_resp) begin
        if (q.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          want = q.pop_front();
          chk("resp_latency", cyc - want.start, want.lat);
          chk("resp_way", int'(way_sel), want.way);
          chk("resp_strobes", int'({load_lru, load_data, set_dirty, data_src, load_tag, pmem_read, pmem_write}),
              int'({1'b1, want.wr, want.wr, 4'b0}));
          pend_hc = want.hc;
          pend_mc = want.mc;
          cnt_pend = 1'b1;
        end
      end
    end
  end

  // Acts as arbiter, tag datapath and physical memory for one request; returns at posedge+1.
  task automatic txn(input bit wr, input bit fh, input int hw, input int lw, input bit vd, input int wl,
                     input int al);
    exp_t x;
    int n = 0, pc = 0;
    bit fill = 1'b0, done = 1'b0;
    if (fh) mhc = (mhc >= MAXC) ? MAXC : mhc + 1;
    else mmc = (mmc >= MAXC) ? MAXC : mmc + 1;
    x.lat = fh ? 1 : 2 + (vd ? wl : 0) + al;
    x.way = fh ? hw : lw;
    x.wr = wr;
    x.lw = lw;
    x.hc = mhc;
    x.mc = mmc;
    x.start = cyc;
    q.push_back(x);
    busy = 1'b1;
    mem_write = wr;
    mem_read = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    hit = fh;
    hit_way = WAY_W'(hw);
    lru_way = WAY_W'(lw);
    victim_dirty = vd;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if (fill) begin
        hit = 1'b1;
        hit_way = WAY_W'(lw);
        fill = 1'b0;
      end
      if (pmem_read | pmem_write) begin
        pc++;
        if (pc == (pmem_read ? al : wl)) begin
          pmem_resp = 1'b1;
          pc = 0;
          fill = pmem_read;
        end
      end
      @(negedge clk);
      done = mem_resp;
      n++;
    end
    if (!done) begin
      bad++;
      $display("FAIL txn_timeout: got no mem_resp expected one within 100 cycles");
      $fatal(1, "transaction timeout");
    end
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    hit = 1'b0;
    victim_dirty = 1'b0;
    pmem_resp = 1'b0;
    busy = 1'b0;
  endtask

  initial begin
    int k;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_hit_count", int'(hit_count), 0);
    chk("reset_miss_count", int'(miss_count), 0);
    chk("reset_outputs", all_outs(), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    txn(1'b0, 1'b1, 1, 0, 1'b0, 1, 1);
    txn(1'b1, 1'b1, 0, 1, 1'b0, 1, 1);
    txn(1'b0, 1'b0, 0, 1, 1'b0, 1, 5);
    txn(1'b1, 1'b0, 1, 1, 1'b1, 3, 2);
    repeat (5) txn(1'b0, 1'b1, 1, 0, 1'b0, 1, 1);
    busy = 1'b1;
    mem_read = 1'b1;
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    @(negedge clk);
    chk("violation_quiet", int'({mem_resp, load_lru, load_data, set_dirty, pmem_read, pmem_write}), 0);
    @(posedge clk);
    #1;
    busy = 1'b0;
    @(negedge clk);
    chk("violation_hits", int'(hit_count), mhc);
    chk("violation_misses", int'(miss_count), mmc);
    @(posedge clk);
    #1;
    busy = 1'b1;
    mem_write = 1'b1;
    victim_dirty = 1'b1;
    lru_way = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("wb_active", int'(pmem_write), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pmem_write", int'(pmem_write), 0);
    chk("rst_outputs", all_outs(), 0);
    chk("rst_hit_count", int'(hit_count), 0);
    chk("rst_miss_count", int'(miss_count), 0);
    mhc = 0;
    mmc = 0;
    mem_write = 1'b0;
    victim_dirty = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    busy = 1'b0;
    repeat (300) begin
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
          int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 5)),
          int'($urandom_range(1, 5)));
      k = int'($urandom_range(0, 2));
      repeat (k) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (3) @(posedge clk);
    if (q.size() != 0) chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
